apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Two-to-one APB arbiter that shares a single downstream APB completer port (e.g. the delayer/peripheral chain) between two upstream APB requesters. It selects one requester per transfer with round-robin priority and regenerates the downstream SETUP/ACCESS phases. It returns the completer response to the granted requester only. An optional watchdog aborts transfers whose completer never raises `pready`.

## Interface
- `TIMEOUT`, 1024 — ACCESS-phase cycle limit before abort (only with `APB_ARB_TIMEOUT_EN`); legal range 1..65535.
- `clock` in 1 — single clock, all state on rising edge.
- `reset` in 1 — asynchronous, active-high.
- `in0_paddr` in 32, `in0_psel` in 1, `in0_penable` in 1, `in0_pprot` in 3, `in0_pwrite` in 1, `in0_pwdata` in 32, `in0_pstrb` in 4 — requester 0 request.
- `in0_pready` out 1, `in0_prdata` out 32, `in0_pslverr` out 1 — requester 0 response.
- `in1_*` — identical port set for requester 1.
- `out_paddr` out 32, `out_psel` out 1, `out_penable` out 1, `out_pprot` out 3, `out_pwrite` out 1, `out_pwdata` out 32, `out_pstrb` out 4 — downstream request.
- `out_pready` in 1, `out_prdata` in 32, `out_pslverr` in 1 — downstream response.

## Operation
- States: IDLE, SETUP, ACCESS. Registers: `state`, `gnt` (1 bit, granted port), `prio` (1 bit, port that wins a tie).
- IDLE: if exactly one `inN_psel`=1, set `gnt`=N. If both are 1, set `gnt`=`prio`. Then go to SETUP. If neither is set, stay in IDLE.
- SETUP: `out_psel`=1, `out_penable`=0, always exactly one cycle, then go to ACCESS.
- ACCESS: `out_psel`=1, `out_penable`=1. When `out_pready`=1, the transfer completes: go to IDLE and set `prio`=~`gnt`.
- Request mux: `out_paddr/pprot/pwrite/pwdata/pstrb` = granted port's inputs in SETUP/ACCESS, and 0 in IDLE.
- Response routing, combinational: the granted port gets `pready`=`out_pready`&(state==ACCESS), `prdata`=`out_prdata`, `pslverr`=`out_pslverr`, each qualified by ACCESS. All other cases drive 0.
- The non-granted port sees `pready`=0 and holds its request per APB rules. It is served in a later IDLE.
- Upstream `inN_penable` is not used for sequencing. A requester that has raised `psel` is assumed to follow APB.
- Any state encoding outside the three states → IDLE.

## Timing
- Reset (async, immediate): state=IDLE, `gnt`=0, `prio`=0. All outputs are 0: `out_psel`, `out_penable`, `out_*` request buses, and `inN_pready/prdata/pslverr`.
- Latency: request sampled in IDLE at cycle 0 → SETUP cycle 1 → ACCESS cycle 2 onward. Upstream completion happens in the same cycle as downstream `out_pready`, giving a minimum of 3 cycles per transfer.
- The completion cycle is followed by one IDLE cycle. Back-to-back requests from the same port are sampled there, and the other port wins a tie.
- A single active requester is always granted regardless of `prio`. `prio` changes only on completion or abort.
- Reset asserted mid-transfer: the transfer is dropped with no upstream `pready`, and outputs go low asynchronously.
- `out_pready` in IDLE or SETUP is ignored.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without `out_pready`.
  - If the counter reaches `TIMEOUT-1` with `out_pready`=0, the transfer aborts in that cycle. The granted port gets `pready`=1, `pslverr`=1, `prdata`=32'h0.
  - After an abort, the next state is IDLE, `prio` flips, and `out_psel/out_penable` drop in the next cycle.
  - `out_pready` arriving in the abort cycle takes precedence and results in a normal completion.
- `APB_ARB_TIMEOUT_EN` undefined: there is no counter, and ACCESS waits indefinitely.

## Test plan
- Single requester: `in0` read 0x1000_0000, downstream `out_pready`=1 on the first ACCESS cycle with `prdata`=0xCAFE_F00D. Expected: `out_psel` is high on cycles 1–2, `out_penable` on cycle 2, and `in0_pready`=1 with `prdata`=0xCAFE_F00D on cycle 2. `in1_pready` stays 0.
- Tie after reset: both ports request simultaneously, each with 2 downstream wait states. Expected: `in0` is served first, then `in1` with its `paddr/pwdata/pstrb` on `out_*`. A renewed tie is then served by `in0`.
- Write with error: `in1` write, `pwdata`=0x1234_5678, `pstrb`=4'b0011, completer answers `pslverr`=1. Expected: `in1_pslverr`=1 only in the completion cycle, and `out_pwrite`=1 throughout SETUP/ACCESS.
- Reset mid-ACCESS: assert `reset` in cycle 2 of a transfer. Expected: all outputs 0 immediately. After release, IDLE is observed and a new tie goes to `in0`.
- Timeout (`APB_ARB_TIMEOUT_EN`, `TIMEOUT`=4): completer never readies. Expected: the granted port gets `pready`=1, `pslverr`=1, `prdata`=0 on the 4th ACCESS cycle. `out_psel` is 0 on the following cycle, and the pending other port is granted next.
- Timeout race (`TIMEOUT`=4): `out_pready`=1 on the 4th ACCESS cycle with `pslverr`=0. Expected: a normal completion with `pslverr`=0.

Source files
------------

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin 2:1 APB arbiter sharing one downstream completer.
// Define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase watchdog (limit TIMEOUT).
module apb_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in0_paddr,
  input  logic        in0_psel,
  input  logic        in0_penable,
  input  logic [2:0]  in0_pprot,
  input  logic        in0_pwrite,
  input  logic [31:0] in0_pwdata,
  input  logic [3:0]  in0_pstrb,
  output logic        in0_pready,
  output logic [31:0] in0_prdata,
  output logic        in0_pslverr,
  input  logic [31:0] in1_paddr,
  input  logic        in1_psel,
  input  logic        in1_penable,
  input  logic [2:0]  in1_pprot,
  input  logic        in1_pwrite,
  input  logic [31:0] in1_pwdata,
  input  logic [3:0]  in1_pstrb,
  output logic        in1_pready,
  output logic [31:0] in1_prdata,
  output logic        in1_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, prio_q, prio_d;
  logic busy, acc, done, abort;
  logic unused;
  assign acc  = state_q == ACCESS;
  assign busy = state_q == SETUP || acc;
  assign done = acc && (out_pready || abort);
  // Upstream penable is not needed: sequencing is regenerated downstream.
  assign unused = ^{in0_penable, in1_penable, TIMEOUT[0]};
`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign abort = acc && !out_pready && cnt_q == 16'(TIMEOUT - 1);
  assign cnt_d = state_q == SETUP ? '0 : (acc && !out_pready) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = IDLE;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: if (in0_psel || in1_psel) begin
        state_d = SETUP;
        gnt_d   = (in0_psel && in1_psel) ? prio_q : in1_psel;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (done) prio_d = ~gnt_q;
              else state_d = ACCESS;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  assign out_psel    = busy;
  assign out_penable = acc;
  assign out_paddr   = busy ? (gnt_q ? in1_paddr  : in0_paddr)  : '0;
  assign out_pprot   = busy ? (gnt_q ? in1_pprot  : in0_pprot)  : '0;
  assign out_pwrite  = busy && (gnt_q ? in1_pwrite : in0_pwrite);
  assign out_pwdata  = busy ? (gnt_q ? in1_pwdata : in0_pwdata) : '0;
  assign out_pstrb   = busy ? (gnt_q ? in1_pstrb  : in0_pstrb)  : '0;
  // An aborted transfer reports an error with zero read data.
  assign in0_pready  = done && !gnt_q;
  assign in1_pready  = done && gnt_q;
  assign in0_prdata  = (acc && !gnt_q && !abort) ? out_prdata : '0;
  assign in1_prdata  = (acc && gnt_q && !abort) ? out_prdata : '0;
  assign in0_pslverr = acc && !gnt_q && (out_pslverr || abort);
  assign in1_pslverr = acc && gnt_q && (out_pslverr || abort);
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed vector table, corner sequences and a randomized
// run against a transaction-level round-robin model of the arbiter.
module tb_apb_arbiter;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] in0_paddr = '0, in1_paddr = '0, in0_pwdata = '0, in1_pwdata = '0;
  logic in0_psel = 1'b0, in1_psel = 1'b0, in0_penable = 1'b0, in1_penable = 1'b0;
  logic [2:0] in0_pprot = '0, in1_pprot = '0;
  logic in0_pwrite = 1'b0, in1_pwrite = 1'b0;
  logic [3:0] in0_pstrb = '0, in1_pstrb = '0;
  logic in0_pready, in1_pready, in0_pslverr, in1_pslverr;
  logic [31:0] in0_prdata, in1_prdata;
  logic [31:0] out_paddr, out_pwdata;
  logic out_psel, out_penable, out_pwrite;
  logic [2:0] out_pprot;
  logic [3:0] out_pstrb;
  logic out_pready = 1'b0, out_pslverr = 1'b0;
  logic [31:0] out_prdata = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clk), .reset(reset),
    .in0_paddr(in0_paddr), .in0_psel(in0_psel), .in0_penable(in0_penable), .in0_pprot(in0_pprot),
    .in0_pwrite(in0_pwrite), .in0_pwdata(in0_pwdata), .in0_pstrb(in0_pstrb),
    .in0_pready(in0_pready), .in0_prdata(in0_prdata), .in0_pslverr(in0_pslverr),
    .in1_paddr(in1_paddr), .in1_psel(in1_psel), .in1_penable(in1_penable), .in1_pprot(in1_pprot),
    .in1_pwrite(in1_pwrite), .in1_pwdata(in1_pwdata), .in1_pstrb(in1_pstrb),
    .in1_pready(in1_pready), .in1_prdata(in1_prdata), .in1_pslverr(in1_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  // ctl = {rst, p0, p1, rdy, err, ab, ps, pe, r0, r1}; src: 0 none, 1 in0, 2 in1
  typedef struct {
    logic [9:0]  ctl;
    logic [31:0] rd;
    int          src;
  } vec_t;

  function automatic vec_t mk(input logic [9:0] ctl, input logic [31:0] rd, input int src);
    vec_t v;
    v.ctl = ctl;
    v.rd  = rd;
    v.src = src;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic expect_out(input logic ps, input logic pe, input int src, input logic r0,
                            input logic r1, input logic ab, input logic [31:0] rd, input logic err);
    logic g0, g1;
    g0 = pe && src == 1;
    g1 = pe && src == 2;
    chk("out_psel", out_psel, ps);
    chk("out_penable", out_penable, pe);
    chk("out_paddr", out_paddr, src == 1 ? in0_paddr : src == 2 ? in1_paddr : 32'h0);
    chk("out_pwdata", out_pwdata, src == 1 ? in0_pwdata : src == 2 ? in1_pwdata : 32'h0);
    chk("out_pstrb", out_pstrb, src == 1 ? in0_pstrb : src == 2 ? in1_pstrb : 4'h0);
    chk("out_pprot", out_pprot, src == 1 ? in0_pprot : src == 2 ? in1_pprot : 3'h0);
    chk("out_pwrite", out_pwrite, src == 1 ? in0_pwrite : src == 2 && in1_pwrite);
    chk("in0_pready", in0_pready, r0);
    chk("in1_pready", in1_pready, r1);
    chk("in0_prdata", in0_prdata, (g0 && !ab) ? rd : 32'h0);
    chk("in1_prdata", in1_prdata, (g1 && !ab) ? rd : 32'h0);
    chk("in0_pslverr", in0_pslverr, g0 && (ab || err));
    chk("in1_pslverr", in1_pslverr, g1 && (ab || err));
  endtask

  task automatic cyc(input vec_t v);
    @(posedge clk);
    #1;
    reset       = v.ctl[9];
    in0_psel    = v.ctl[8];
    in1_psel    = v.ctl[7];
    out_pready  = v.ctl[6];
    out_pslverr = v.ctl[5];
    out_prdata  = v.rd;
    @(negedge clk);
    expect_out(v.ctl[3], v.ctl[2], v.src, v.ctl[1], v.ctl[0], v.ctl[4], v.rd, v.ctl[5]);
  endtask

  task automatic new_fields(input int i);
    if (i == 0) begin
      in0_paddr = $urandom; in0_pwdata = $urandom;
      in0_pstrb = 4'($urandom); in0_pprot = 3'($urandom); in0_pwrite = 1'($urandom);
    end else begin
      in1_paddr = $urandom; in1_pwdata = $urandom;
      in1_pstrb = 4'($urandom); in1_pprot = 3'($urandom); in1_pwrite = 1'($urandom);
    end
  endtask

  vec_t tbl[20];
  logic [1:0] pend;
  logic prio, win, rdy, ab, err, act;
  int phase, k, w;

  initial begin
    in0_paddr = 32'h1000_0000; in0_pwdata = 32'hA0A0_A0A0; in0_pstrb = 4'hF; in0_pprot = 3'b001;
    in1_paddr = 32'h2000_0000; in1_pwdata = 32'h5B5B_5B5B; in1_pstrb = 4'b0101; in1_pprot = 3'b010;
    in1_pwrite = 1'b1;
    tbl[0]  = mk(10'b1_00_000_00_00, 32'h0, 0);
    tbl[1]  = mk(10'b0_10_000_00_00, 32'h0, 0);
    tbl[2]  = mk(10'b0_10_100_10_00, 32'hDEAD_BEEF, 1);
    tbl[3]  = mk(10'b0_10_100_11_10, 32'hCAFE_F00D, 1);
    tbl[4]  = mk(10'b0_00_100_00_00, 32'h0BAD_0BAD, 0);
    tbl[5]  = mk(10'b1_00_000_00_00, 32'h0, 0);
    tbl[6]  = mk(10'b0_11_000_00_00, 32'h0, 0);
    tbl[7]  = mk(10'b0_11_000_10_00, 32'h0, 1);
    tbl[8]  = mk(10'b0_11_000_11_00, 32'h0000_0011, 1);
    tbl[9]  = mk(10'b0_11_000_11_00, 32'h0000_0022, 1);
    tbl[10] = mk(10'b0_11_100_11_10, 32'hAAAA_0000, 1);
    tbl[11] = mk(10'b0_11_000_00_00, 32'h0, 0);
    tbl[12] = mk(10'b0_11_000_10_00, 32'h0, 2);
    tbl[13] = mk(10'b0_11_000_11_00, 32'h0000_0033, 2);
    tbl[14] = mk(10'b0_11_000_11_00, 32'h0000_0044, 2);
    tbl[15] = mk(10'b0_11_100_11_01, 32'hBBBB_0000, 2);
    tbl[16] = mk(10'b0_11_000_00_00, 32'h0, 0);
    tbl[17] = mk(10'b0_11_000_10_00, 32'h0, 1);
    tbl[18] = mk(10'b0_11_100_11_10, 32'hCCCC_0000, 1);
    tbl[19] = mk(10'b0_00_000_00_00, 32'h0, 0);
    for (int i = 0; i < 20; i++) cyc(tbl[i]);

    // write with completer error on in1
    in1_pwdata = 32'h1234_5678; in1_pstrb = 4'b0011;
    cyc(mk(10'b0_01_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_01_000_10_00, 32'h0, 2));
    cyc(mk(10'b0_01_000_11_00, 32'h0, 2));
    cyc(mk(10'b0_01_110_11_01, 32'h0000_0077, 2));
    cyc(mk(10'b0_00_010_00_00, 32'h0, 0));

    // reset asserted mid-ACCESS
    cyc(mk(10'b0_10_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_10_000_10_00, 32'h0, 1));
    cyc(mk(10'b0_10_000_11_00, 32'h0000_0099, 1));
    #1 reset = 1'b1;
    #1 expect_out(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(mk(10'b1_10_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_11_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_11_000_10_00, 32'h0, 1));
    cyc(mk(10'b0_01_100_11_10, 32'h0000_0055, 1));
    cyc(mk(10'b0_01_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_01_000_10_00, 32'h0, 2));
    cyc(mk(10'b0_00_100_11_01, 32'h0000_0066, 2));

`ifdef APB_ARB_TIMEOUT_EN
    // watchdog abort, then the pending port is served
    cyc(mk(10'b1_00_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_11_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_11_000_10_00, 32'h0, 1));
    cyc(mk(10'b0_11_000_11_00, 32'h1, 1));
    cyc(mk(10'b0_11_000_11_00, 32'h2, 1));
    cyc(mk(10'b0_11_000_11_00, 32'h3, 1));
    cyc(mk(10'b0_11_001_11_10, 32'h4, 1));
    cyc(mk(10'b0_01_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_01_000_10_00, 32'h0, 2));
    cyc(mk(10'b0_01_100_11_01, 32'h0000_0088, 2));
    // ready wins against the watchdog in the limit cycle
    cyc(mk(10'b0_10_000_00_00, 32'h0, 0));
    cyc(mk(10'b0_10_000_10_00, 32'h0, 1));
    cyc(mk(10'b0_10_000_11_00, 32'h1, 1));
    cyc(mk(10'b0_10_000_11_00, 32'h2, 1));
    cyc(mk(10'b0_10_000_11_00, 32'h3, 1));
    cyc(mk(10'b0_10_100_11_10, 32'h0000_0055, 1));
    cyc(mk(10'b0_00_000_00_00, 32'h0, 0));
`endif

    // randomized traffic against a round-robin transaction model
    cyc(mk(10'b1_00_000_00_00, 32'h0, 0));
    pend = 2'b00; prio = 1'b0; win = 1'b0; phase = 0; k = 0; w = 0;
    for (int n = 0; n < 3000; n++) begin
      rdy = phase == 2 ? (k == w) : 1'($urandom_range(0, 1));
      err = 1'($urandom_range(0, 1));
      ab  = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      ab = phase == 2 && !rdy && k == TMO - 1;
`endif
      act = phase == 2 && (rdy || ab);
      cyc(mk({1'b0, pend[0], pend[1], rdy, err, ab, phase != 0, phase == 2, act && !win, act && win},
             $urandom, phase == 0 ? 0 : int'(win) + 1));
      if (phase == 0) begin
        if (pend != 2'b00) begin
          win = pend == 2'b11 ? prio : pend[1];
          phase = 1;
        end
      end else if (phase == 1) begin
        phase = 2; k = 0; w = $urandom_range(0, 5);
      end else if (act) begin
        prio = !win; pend[win] = 1'b0; phase = 0;
      end else k++;
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          new_fields(i);
        end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
